// File: rtl/parity_scan_pkg.sv
// Shared types and defaults for the parity scan engine.
// FSM state encoding plus default geometry.
package parity_scan_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/parity_scan_engine_parity_check.sv
// Combinational even-parity compare of one data word.
// ok is high when data plus parity bit has even weight.
module parity_check
  import parity_scan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par,
  output logic              ok
);

  assign ok = ~((^data) ^ par);

endmodule

// File: rtl/parity_scan_engine.sv
// Sequential parity scan over an external memory.
// Optional PARITY_SCAN_ERR_CAPTURE_EN adds first_err_addr.
module parity_scan_engine
  import parity_scan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_par,
  output logic              chk_valid,
  output logic              match,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_cnt,
  output logic              err_sticky
`ifdef PARITY_SCAN_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] first_err_addr
`endif
);

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                chk_valid_q, chk_valid_d;
  logic [ADDR_W:0]     err_cnt_q, err_cnt_d;
  logic                err_sticky_q, err_sticky_d;
  logic                par_ok;
  logic                go;
  logic                mis;

  parity_check #(
    .DATA_W(DATA_W)
  ) u_parity_check (
    .data(mem_data),
    .par (mem_par),
    .ok  (par_ok)
  );

  // abort wins over start; a pass only launches from IDLE
  assign go  = (state_q == IDLE) & start & ~abort;
  assign mis = chk_valid_q & ~par_ok;

  // next state, address stepping and read strobe
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mem_rd  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = SCAN;
          addr_d  = '0;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          addr_d  = '0;
        end else begin
          mem_rd = 1'b1;
          if (addr_q == LAST) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + A_ONE;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          addr_d  = '0;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
    chk_valid_d = mem_rd;
  end

  // mismatch counter and sticky flag, cleared by an accepted start
  always_comb begin
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (go) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end else if (mis) begin
      err_cnt_d    = err_cnt_q + CNT_ONE;
      err_sticky_d = 1'b1;
    end
  end

  // state and pass registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      chk_valid_q  <= 1'b0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      chk_valid_q  <= chk_valid_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

`ifdef PARITY_SCAN_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
  logic [ADDR_W-1:0] first_q, first_d;

  // track the address under check and latch the first bad one
  always_comb begin
    chk_addr_d = mem_rd ? addr_q : chk_addr_q;
    first_d    = first_q;
    if (go) begin
      first_d = '0;
    end else if (mis && !err_sticky_q) begin
      first_d = chk_addr_q;
    end
  end

  // capture registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_addr_q <= '0;
      first_q    <= '0;
    end else begin
      chk_addr_q <= chk_addr_d;
      first_q    <= first_d;
    end
  end

  assign first_err_addr = first_q;
`endif

  assign mem_addr   = addr_q;
  assign chk_valid  = chk_valid_q;
  assign match      = chk_valid_q & par_ok;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_parity_scan_engine.sv
// Directed plus random bench for parity_scan_engine.
// Memory and expected results come from a queue-based model.
module tb_parity_scan_engine;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data = '0;
  logic              mem_par = 1'b0;
  logic              chk_valid;
  logic              match;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   err_cnt;
  logic              err_sticky;
`ifdef PARITY_SCAN_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] first_err_addr;
`endif

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              mem_p [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  parity_scan_engine #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_par       (mem_par),
    .chk_valid     (chk_valid),
    .match         (match),
    .busy          (busy),
    .done          (done),
    .err_cnt       (err_cnt),
    .err_sticky    (err_sticky)
`ifdef PARITY_SCAN_ERR_CAPTURE_EN
    ,
    .first_err_addr(first_err_addr)
`endif
  );

  always #5 clk = ~clk;

  // memory answers one cycle after a read, junk otherwise
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_data <= mem_d[mem_addr];
      mem_par  <= mem_p[mem_addr];
    end else begin
      mem_data <= DATA_W'($urandom);
      mem_par  <= 1'($urandom);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit entry_ok(input int i);
    return ($countones({mem_d[i], mem_p[i]}) % 2) == 0;
  endfunction

  task automatic fill_good();
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = 8'h1F;
      mem_p[i] = 1'b1;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = DATA_W'($urandom);
      mem_p[i] = 1'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".mem_rd"}, mem_rd, 0);
    check({tag, ".mem_addr"}, mem_addr, 0);
    check({tag, ".chk_valid"}, chk_valid, 0);
    check({tag, ".match"}, match, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".err_cnt"}, err_cnt, 0);
    check({tag, ".err_sticky"}, err_sticky, 0);
`ifdef PARITY_SCAN_ERR_CAPTURE_EN
    check({tag, ".first_err"}, first_err_addr, 0);
`endif
  endtask

  // one pass; abort_at/restart_at are cycles after start (0 = none)
  task automatic run_pass(input string tag,
                          input int abort_at,
                          input int restart_at);
    int rd_q[$];
    bit m_q[$];
    int done_q[$];
    int end_cyc;
    int n_exp;
    int e_cnt;
    int e_first;
    int e_end;
    end_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      abort = (cyc == abort_at);
      #1;
      if (mem_rd) rd_q.push_back(int'(mem_addr));
      if (chk_valid) m_q.push_back(match);
      if (done) done_q.push_back(cyc);
      if (abort_at == 0 && cyc == DEPTH + 1) begin
        check({tag, ".drain_addr"}, mem_addr, DEPTH - 1);
        check({tag, ".drain_rd"}, mem_rd, 0);
      end
      if (!busy) begin
        end_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    n_exp = (abort_at == 0) ? DEPTH
          : ((abort_at - 1 < DEPTH) ? abort_at - 1 : DEPTH);
    e_end = (abort_at == 0) ? DEPTH + 3 : abort_at + 1;
    e_cnt = 0;
    e_first = -1;
    for (int i = 0; i < n_exp; i++) begin
      if (!entry_ok(i)) begin
        e_cnt++;
        if (e_first < 0) e_first = i;
      end
    end
    check({tag, ".end_cycle"}, end_cyc, e_end);
    check({tag, ".n_reads"}, rd_q.size(), n_exp);
    for (int i = 0; i < rd_q.size() && i < n_exp; i++)
      check({tag, ".rd_addr"}, rd_q[i], i);
    check({tag, ".n_checks"}, m_q.size(), n_exp);
    for (int i = 0; i < m_q.size() && i < n_exp; i++)
      check({tag, ".match"}, m_q[i], entry_ok(i));
    if (abort_at == 0) begin
      check({tag, ".n_done"}, done_q.size(), 1);
      if (done_q.size() > 0)
        check({tag, ".done_cyc"}, done_q[0], DEPTH + 2);
    end else begin
      check({tag, ".n_done"}, done_q.size(), 0);
    end
    check({tag, ".err_cnt"}, err_cnt, e_cnt);
    check({tag, ".err_sticky"}, err_sticky, e_cnt > 0);
`ifdef PARITY_SCAN_ERR_CAPTURE_EN
    check({tag, ".first_err"}, first_err_addr,
          (e_first < 0) ? 0 : e_first);
`endif
  endtask

  initial begin
    fill_good();
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // all entries good
    run_pass("all_good", 0, 0);

    // entries 3 and 9 corrupt
    fill_good();
    mem_p[3] = 1'b0;
    mem_p[9] = 1'b0;
    run_pass("two_bad", 0, 0);

    // abort 5 cycles in with entry 2 corrupt
    fill_good();
    mem_p[2] = 1'b0;
    run_pass("abort5", 5, 0);
    repeat (2) @(negedge clk);

    // abort while draining still counts the last entry
    fill_good();
    mem_p[15] = 1'b0;
    run_pass("abort_drain", DEPTH + 1, 0);

    // second start mid-pass is ignored
    fill_good();
    mem_p[6] = 1'b0;
    run_pass("restart7", 0, 7);

    // reset mid-pass at cycle 8
    fill_good();
    mem_p[2] = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    check("pre_reset.err_cnt", err_cnt, 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_pass("after_reset", 0, 0);

    // start and abort together in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    begin
      int rd_seen;
      int busy_seen;
      rd_seen = 0;
      busy_seen = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        rd_seen += int'(mem_rd);
        busy_seen += int'(busy);
      end
      check("start_abort.rd", rd_seen, 0);
      check("start_abort.busy", busy_seen, 0);
    end

    // random memory contents, some with random aborts
    for (int k = 0; k < 6; k++) begin
      fill_random();
      if (k % 2 == 1)
        run_pass("rand_abort", $urandom_range(2, DEPTH + 1), 0);
      else
        run_pass("rand", 0, 0);
      repeat (2) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
